// File: rtl/lsu_unit_pkg.sv
// Shared types for the load/store unit: access size and controller state.
package lsu_unit_pkg;

   typedef enum logic [1:0] {
      LSU_B = 2'd0,
      LSU_H = 2'd1,
      LSU_W = 2'd2
   } lsu_type;

   typedef enum logic [1:0] {
      LSU_IDLE        = 2'd0,
      LSU_WAIT_GNT    = 2'd1,
      LSU_WAIT_RVALID = 2'd2,
      LSU_RESP        = 2'd3
   } lsu_state;

endpackage

// File: rtl/lsu_unit_align.sv
// Lane alignment for the LSU: byte enables, store replication, load extract/extend
// and misalignment detection. Purely combinational.
module lsu_align
   import lsu_unit_pkg::*;
(
   input  lsu_type     type_i,
   input  logic [1:0]  off_i,
   input  logic        sext_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [31:0] w_shift;

   always_comb begin
      w_shift      = rdata_i >> {off_i, 3'b000};
      be_o         = 4'b0000;
      wdata_o      = wdata_i;
      rdata_o      = rdata_i;
      misaligned_o = 1'b0;
      case (type_i)
         LSU_B: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{sext_i & w_shift[7]}}, w_shift[7:0]};
         end
         LSU_H: begin
            be_o         = 4'b0011 << off_i;
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = {{16{sext_i & w_shift[15]}}, w_shift[15:0]};
            misaligned_o = off_i[0];
         end
         LSU_W: begin
            be_o         = 4'b1111;
            misaligned_o = (off_i != 2'b00);
         end
         // An undefined size code is reported as an error rather than touching memory.
         default: misaligned_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: one request/grant/rvalid transaction at a time on the data port,
// returning aligned and extended load data to the register-file write path.
//
// state           | meaning
// ----------------+-----------------------------------------------------------
// LSU_IDLE        | ready for a request; latches the access on req_i
// LSU_WAIT_GNT    | data_req_o high, address/be/wdata held until grant
// LSU_WAIT_RVALID | request granted, waiting for the response
// LSU_RESP        | one-cycle done_o pulse with err_o / rf_we_o
module lsu_unit
   import lsu_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   output logic              ready_o,
   input  logic              we_i,
   input  lsu_type           type_i,
   input  logic              sext_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        rf_waddr_i,
   output logic              data_req_o,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic              data_err_i,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [DATA_W-1:0] data_wdata_o,
   input  logic [DATA_W-1:0] data_rdata_i,
   output logic              rf_we_o,
   output logic [4:0]        rf_waddr_o,
   output logic [DATA_W-1:0] rf_wdata_o,
   output logic              done_o,
   output logic              err_o
);

   lsu_state          r_state;
   logic              r_ready;
   logic              r_data_req;
   logic              r_done;
   logic              r_err;
   logic              r_rf_we;
   logic              r_we;
   lsu_type           r_type;
   logic              r_sext;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [4:0]        r_waddr;
   logic [DATA_W-1:0] r_rdata;

   lsu_type           w_type;
   logic [1:0]        w_off;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rdata;
   logic              w_misaligned;

   // Misalignment must be judged on the incoming request at accept time;
   // afterwards everything comes from the latched copy.
   assign w_type = (r_state == LSU_IDLE) ? type_i : r_type;
   assign w_off  = (r_state == LSU_IDLE) ? addr_i[1:0] : r_addr[1:0];

   lsu_align u_align (
      .type_i       (w_type),
      .off_i        (w_off),
      .sext_i       (r_sext),
      .wdata_i      (r_wdata),
      .rdata_i      (r_rdata),
      .be_o         (w_be),
      .wdata_o      (w_wdata),
      .rdata_o      (w_rdata),
      .misaligned_o (w_misaligned)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= LSU_IDLE;
         r_ready    <= 1'b1;
         r_data_req <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rf_we    <= 1'b0;
         r_we       <= 1'b0;
         r_type     <= LSU_B;
         r_sext     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_waddr    <= '0;
         r_rdata    <= '0;
      end else begin
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_rf_we <= 1'b0;
         case (r_state)
            LSU_IDLE: begin
               if (req_i) begin
                  r_we    <= we_i;
                  r_type  <= type_i;
                  r_sext  <= sext_i;
                  r_addr  <= addr_i;
                  r_wdata <= wdata_i;
                  r_waddr <= rf_waddr_i;
                  r_ready <= 1'b0;
                  if (w_misaligned) begin
                     r_state <= LSU_RESP;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state    <= LSU_WAIT_GNT;
                     r_data_req <= 1'b1;
                  end
               end
            end
            LSU_WAIT_GNT: begin
               if (data_gnt_i) begin
                  r_state    <= LSU_WAIT_RVALID;
                  r_data_req <= 1'b0;
               end
            end
            LSU_WAIT_RVALID: begin
               if (data_rvalid_i) begin
                  r_state <= LSU_RESP;
                  r_rdata <= data_rdata_i;
                  r_done  <= 1'b1;
                  r_err   <= data_err_i;
                  r_rf_we <= ~r_we & ~data_err_i;
               end
            end
            LSU_RESP: begin
               r_state <= LSU_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= LSU_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Bus-side signals are only driven while a request is outstanding.
   assign ready_o      = r_ready;
   assign data_req_o   = r_data_req;
   assign data_addr_o  = r_data_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign data_we_o    = r_data_req & r_we;
   assign data_be_o    = r_data_req ? w_be : 4'b0000;
   assign data_wdata_o = r_data_req ? w_wdata : '0;
   assign rf_we_o      = r_rf_we;
   assign rf_waddr_o   = r_waddr;
   assign rf_wdata_o   = w_rdata;
   assign done_o       = r_done;
   assign err_o        = r_err;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: vector table with a cycle-accurate memory responder,
// plus hand-written reset sequences.
module tb_lsu_unit;
   import lsu_unit_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        ready_o;
   logic        we_i;
   lsu_type     type_i;
   logic        sext_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [4:0]  rf_waddr_i;
   logic        data_req_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic        data_err_i;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic [31:0] data_rdata_i;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        done_o;
   logic        err_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   lsu_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .ready_o(ready_o),
      .we_i(we_i), .type_i(type_i), .sext_i(sext_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .rf_waddr_i(rf_waddr_i),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
      .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
      .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .done_o(done_o), .err_o(err_o)
   );

   typedef struct {
      logic        we;
      lsu_type     ty;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  waddr;
      int          gw;
      int          rw;
      logic        spur;
      logic [31:0] rdata;
      logic        berr;
      logic        x_mis;
      logic [31:0] x_daddr;
      logic [3:0]  x_be;
      logic [31:0] x_wd;
      logic        x_rfwe;
      logic [31:0] x_rfwd;
      logic        x_err;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input lsu_type ty, input logic sext,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] waddr, input int gw, input int rw,
                               input logic spur, input logic [31:0] rdata, input logic berr,
                               input logic x_mis, input logic [31:0] x_daddr,
                               input logic [3:0] x_be, input logic [31:0] x_wd,
                               input logic x_rfwe, input logic [31:0] x_rfwd,
                               input logic x_err);
      vec_t v;
      v.we = we; v.ty = ty; v.sext = sext; v.addr = addr; v.wdata = wdata;
      v.waddr = waddr; v.gw = gw; v.rw = rw; v.spur = spur; v.rdata = rdata;
      v.berr = berr; v.x_mis = x_mis; v.x_daddr = x_daddr; v.x_be = x_be;
      v.x_wd = x_wd; v.x_rfwe = x_rfwe; v.x_rfwd = x_rfwd; v.x_err = x_err;
      return v;
   endfunction

   task automatic idle_inputs();
      req_i = 1'b0; we_i = 1'b0; type_i = LSU_B; sext_i = 1'b0;
      addr_i = '0; wdata_i = '0; rf_waddr_i = '0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  g_cyc;
      int  r_cyc;
      int  reqs;
      int  dones;
      int  done_c;
      bit  seen_req;
      int  x_done;
      g_cyc = -1; r_cyc = -1; reqs = 0; dones = 0; done_c = -1; seen_req = 0;
      x_done = v.x_mis ? 1 : 3 + v.gw + v.rw;
      @(negedge clk_i);
      check($sformatf("v%0d ready_at_accept", idx), 32'(ready_o), 32'd1);
      req_i = 1'b1; we_i = v.we; type_i = v.ty; sext_i = v.sext;
      addr_i = v.addr; wdata_i = v.wdata; rf_waddr_i = v.waddr;
      for (int c = 1; c < 40; c++) begin
         @(negedge clk_i);
         if (c == 1) idle_inputs();
         data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
         if (data_req_o) begin
            reqs++;
            if (!seen_req) begin
               seen_req = 1;
               check($sformatf("v%0d req_cycle", idx), 32'(c), 32'd1);
               check($sformatf("v%0d data_addr", idx), data_addr_o, v.x_daddr);
               check($sformatf("v%0d data_be", idx), 32'(data_be_o), 32'(v.x_be));
               check($sformatf("v%0d data_we", idx), 32'(data_we_o), 32'(v.we));
               if (v.we) check($sformatf("v%0d data_wdata", idx), data_wdata_o, v.x_wd);
            end
            if (c >= 1 + v.gw) begin
               data_gnt_i = 1'b1;
               g_cyc = c;
               r_cyc = c + 1 + v.rw;
            end else begin
               check($sformatf("v%0d addr_held", idx), data_addr_o, v.x_daddr);
               if (v.spur) begin
                  data_rvalid_i = 1'b1;
                  data_rdata_i  = 32'h5555_5555;
               end
            end
         end
         if (c == r_cyc) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = v.rdata;
            data_err_i    = v.berr;
         end
         if (done_o) begin
            dones++;
            done_c = c;
            check($sformatf("v%0d err", idx), 32'(err_o), 32'(v.x_err));
            check($sformatf("v%0d rf_we", idx), 32'(rf_we_o), 32'(v.x_rfwe));
            check($sformatf("v%0d ready_in_resp", idx), 32'(ready_o), 32'd0);
            if (v.x_rfwe) begin
               check($sformatf("v%0d rf_wdata", idx), rf_wdata_o, v.x_rfwd);
               check($sformatf("v%0d rf_waddr", idx), 32'(rf_waddr_o), 32'(v.waddr));
            end
         end
         if (done_c >= 0 && c == done_c + 1) begin
            check($sformatf("v%0d ready_after", idx), 32'(ready_o), 32'd1);
            break;
         end
      end
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      check($sformatf("v%0d done_count", idx), 32'(dones), 32'd1);
      check($sformatf("v%0d done_cycle", idx), 32'(done_c), 32'(x_done));
      check($sformatf("v%0d req_cycles", idx), 32'(reqs), v.x_mis ? 32'd0 : 32'(v.gw + 1));
   endtask

   initial begin
      int late_done;
      //             we  ty     sx addr         wdata         wa gw rw sp rdata         be  mis daddr        be       wd            rfwe rfwd          err
      vecs[0]  = mk(1, LSU_W, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 32'h0,        0);
      vecs[1]  = mk(0, LSU_B, 1, 32'h203, 32'h0,        5, 0, 0, 0, 32'h80FFFFFF, 0, 0, 32'h200, 4'b1000, 32'h0,        1, 32'hFFFFFF80, 0);
      vecs[2]  = mk(0, LSU_B, 0, 32'h203, 32'h0,        5, 0, 0, 0, 32'h80FFFFFF, 0, 0, 32'h200, 4'b1000, 32'h0,        1, 32'h00000080, 0);
      vecs[3]  = mk(0, LSU_H, 0, 32'h012, 32'h0,        9, 0, 1, 0, 32'h1234ABCD, 0, 0, 32'h010, 4'b1100, 32'h0,        1, 32'h00001234, 0);
      vecs[4]  = mk(0, LSU_W, 0, 32'h040, 32'h0,       12, 4, 2, 1, 32'hCAFEF00D, 0, 0, 32'h040, 4'b1111, 32'h0,        1, 32'hCAFEF00D, 0);
      vecs[5]  = mk(1, LSU_W, 0, 32'h102, 32'h11223344, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        0, 32'h0,        1);
      vecs[6]  = mk(0, LSU_W, 0, 32'h080, 32'h0,        7, 1, 0, 0, 32'h12345678, 1, 0, 32'h080, 4'b1111, 32'h0,        0, 32'h0,        1);
      vecs[7]  = mk(1, LSU_B, 0, 32'h101, 32'h000000A5, 0, 0, 0, 0, 32'h0,        0, 0, 32'h100, 4'b0010, 32'hA5A5A5A5, 0, 32'h0,        0);
      vecs[8]  = mk(1, LSU_H, 0, 32'h102, 32'h0000BEEF, 0, 2, 0, 0, 32'h0,        0, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 0, 32'h0,        0);
      vecs[9]  = mk(0, LSU_H, 1, 32'h102, 32'h0,        3, 0, 0, 0, 32'h80010000, 0, 0, 32'h100, 4'b1100, 32'h0,        1, 32'hFFFF8001, 0);
      vecs[10] = mk(0, LSU_H, 0, 32'h001, 32'h0,        4, 0, 0, 0, 32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        0, 32'h0,        1);

      idle_inputs();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      check("rst ready", 32'(ready_o), 32'd1);
      check("rst data_req", 32'(data_req_o), 32'd0);
      check("rst done", 32'(done_o), 32'd0);
      check("rst err", 32'(err_o), 32'd0);
      check("rst rf_we", 32'(rf_we_o), 32'd0);
      check("rst data_be", 32'(data_be_o), 32'd0);
      check("rst data_addr", data_addr_o, 32'd0);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Reset while waiting for rvalid; the late response must be dropped.
      @(negedge clk_i);
      req_i = 1'b1; type_i = LSU_W; addr_i = 32'h300; rf_waddr_i = 5'd3;
      @(negedge clk_i);
      idle_inputs();
      check("rstmid req_up", 32'(data_req_o), 32'd1);
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      check("rstmid req_dropped", 32'(data_req_o), 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("rstmid ready", 32'(ready_o), 32'd1);
      data_rvalid_i = 1'b1; data_rdata_i = 32'hFEEDFACE;
      late_done = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         data_rvalid_i = 1'b0;
         if (done_o || rf_we_o) late_done++;
      end
      check("rstmid no_done", 32'(late_done), 32'd0);
      check("rstmid ready_end", 32'(ready_o), 32'd1);

      // A normal transaction still works after the abandoned one.
      run_vec(vecs[3], 11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
